// File: rtl/axi_lite_ram.sv
// AXI4-Lite slave backed by a 2**ADDR_WIDTH x 32-bit RAM.
// Write and read channels run independent single-outstanding FSMs.
module axi_lite_ram #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        AWvalid,
  output logic        AWready,
  input  logic [31:0] AWdata,
  input  logic [2:0]  AWprot,
  input  logic        Wvalid,
  output logic        Wready,
  input  logic [31:0] Wdata,
  input  logic [3:0]  Wstrb,
  output logic        Bvalid,
  input  logic        Bready,
  input  logic        ARvalid,
  output logic        ARready,
  input  logic [31:0] ARdata,
  input  logic [2:0]  ARprot,
  output logic        Rvalid,
  input  logic        RReady,
  output logic [31:0] Rdata
);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_COMMIT = 2'd1, W_RESP = 2'd2} w_state_e;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_FETCH = 2'd1, R_DATA = 2'd2} r_state_e;

  function automatic logic in_range(input logic [31:0] addr);
    return addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2];
  endfunction

  logic [31:0] mem_q [2**ADDR_WIDTH];

  w_state_e    w_state_q, w_state_d;
  logic        aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic [31:0] awaddr_q, awaddr_d, wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;

  r_state_e    r_state_q, r_state_d;
  logic [31:0] araddr_q, araddr_d, rdata_q, rdata_d;
  logic        arready_q, arready_d, rvalid_q, rvalid_d;

  logic [ADDR_WIDTH-1:0] widx_s, ridx_s;
  logic                  unused_s;

  assign widx_s   = awaddr_q[ADDR_WIDTH+1:2];
  assign ridx_s   = araddr_q[ADDR_WIDTH+1:2];
  assign unused_s = ^{AWprot, ARprot, awaddr_q[1:0], araddr_q[1:0]};

  // Write FSM state, latches and registered write-side outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_state_q <= W_IDLE;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      awaddr_q  <= 32'h0;
      wdata_q   <= 32'h0;
      wstrb_q   <= 4'h0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
    end
  end

  // Write next-state: AW and W latch independently, commit once both are held
  always_comb begin
    w_state_d = w_state_q;
    aw_got_d  = aw_got_q;
    w_got_d   = w_got_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    case (w_state_q)
      W_IDLE: begin
        if (AWvalid && awready_q) begin
          aw_got_d = 1'b1;
          awaddr_d = AWdata;
        end else begin
          aw_got_d = aw_got_q;
        end
        if (Wvalid && wready_q) begin
          w_got_d = 1'b1;
          wdata_d = Wdata;
          wstrb_d = Wstrb;
        end else begin
          w_got_d = w_got_q;
        end
        if (aw_got_d && w_got_d) begin
          w_state_d = W_COMMIT;
        end else begin
          w_state_d = W_IDLE;
        end
      end
      W_COMMIT: w_state_d = W_RESP;
      W_RESP: begin
        if (bvalid_q && Bready) begin
          w_state_d = W_IDLE;
          aw_got_d  = 1'b0;
          w_got_d   = 1'b0;
        end else begin
          w_state_d = W_RESP;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write outputs decoded from the next state so they are registered
  always_comb begin
    awready_d = (w_state_d == W_IDLE) && !aw_got_d;
    wready_d  = (w_state_d == W_IDLE) && !w_got_d;
    bvalid_d  = (w_state_d == W_RESP);
  end

  // Byte-enabled RAM write; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (w_state_q == W_COMMIT && in_range(awaddr_q)) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) begin
          mem_q[widx_s][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  // Read FSM state, address latch and registered read-side outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state_q <= R_IDLE;
      araddr_q  <= 32'h0;
      rdata_q   <= 32'h0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      araddr_q  <= araddr_d;
      rdata_q   <= rdata_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
    end
  end

  // Read next-state; the fetch samples the RAM before a same-cycle commit lands
  always_comb begin
    r_state_d = r_state_q;
    araddr_d  = araddr_q;
    rdata_d   = rdata_q;
    case (r_state_q)
      R_IDLE: begin
        if (ARvalid && arready_q) begin
          r_state_d = R_FETCH;
          araddr_d  = ARdata;
        end else begin
          r_state_d = R_IDLE;
        end
      end
      R_FETCH: begin
        r_state_d = R_DATA;
        if (in_range(araddr_q)) begin
          rdata_d = mem_q[ridx_s];
        end else begin
          rdata_d = 32'h0;
        end
      end
      R_DATA: begin
        if (rvalid_q && RReady) begin
          r_state_d = R_IDLE;
        end else begin
          r_state_d = R_DATA;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read outputs decoded from the next state
  always_comb begin
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
  end

  assign AWready = awready_q;
  assign Wready  = wready_q;
  assign Bvalid  = bvalid_q;
  assign ARready = arready_q;
  assign Rvalid  = rvalid_q;
  assign Rdata   = rdata_q;

endmodule

// File: tb/tb_axi_lite_ram.sv
// Scoreboard bench for axi_lite_ram: a word model predicts read data,
// expected reads are queued at AR issue and popped at the R handshake.
module tb_axi_lite_ram;

  logic        clk, rstn;
  logic        AWvalid, AWready, Wvalid, Wready, Bvalid, Bready;
  logic        ARvalid, ARready, Rvalid, RReady;
  logic [31:0] AWdata, Wdata, ARdata, Rdata;
  logic [2:0]  AWprot, ARprot;
  logic [3:0]  Wstrb;

  int          vec_cnt = 0;
  int          err_cnt = 0;
  logic [31:0] exp_q [$];
  logic [31:0] model [0:1023];

  axi_lite_ram #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0000_0000)) dut (
    .clk(clk), .rstn(rstn),
    .AWvalid(AWvalid), .AWready(AWready), .AWdata(AWdata), .AWprot(AWprot),
    .Wvalid(Wvalid), .Wready(Wready), .Wdata(Wdata), .Wstrb(Wstrb),
    .Bvalid(Bvalid), .Bready(Bready),
    .ARvalid(ARvalid), .ARready(ARready), .ARdata(ARdata), .ARprot(ARprot),
    .Rvalid(Rvalid), .RReady(RReady), .Rdata(Rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    if (addr[31:12] == 20'h0) begin
      for (int i = 0; i < 4; i++)
        if (strb[i]) model[addr[11:2]][8*i +: 8] = data[8*i +: 8];
    end
  endtask

  task automatic write_txn(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_hold);
    int cyc, n;
    bit aw_done, w_done, aw_hs, w_hs;
    cyc = 0; aw_done = 0; w_done = 0;
    while (!(aw_done && w_done) && cyc < 50) begin
      @(negedge clk);
      if (aw_done && !w_done) begin
        vec_cnt++;
        if (AWready !== 1'b0 || Wready !== 1'b1)
          begin err_cnt++; $display("FAIL aw_latched_ready: AWready=%b Wready=%b, want 0/1", AWready, Wready); end
      end
      if (w_done && !aw_done) begin
        vec_cnt++;
        if (Wready !== 1'b0 || AWready !== 1'b1)
          begin err_cnt++; $display("FAIL w_latched_ready: Wready=%b AWready=%b, want 0/1", Wready, AWready); end
      end
      AWvalid = !aw_done && (cyc >= aw_dly); AWdata = addr; AWprot = 3'd2;
      Wvalid  = !w_done && (cyc >= w_dly);   Wdata  = data; Wstrb  = strb;
      aw_hs = AWvalid && AWready;
      w_hs  = Wvalid && Wready;
      @(posedge clk);
      if (aw_hs) aw_done = 1;
      if (w_hs) w_done = 1;
      cyc++;
    end
    vec_cnt++;
    if (!(aw_done && w_done))
      begin err_cnt++; $display("FAIL wr_handshake: aw_done=%b w_done=%b, want 1/1", aw_done, w_done); end
    model_write(addr, data, strb);
    n = 0;
    do begin
      @(negedge clk); AWvalid = 0; Wvalid = 0; n++;
    end while (Bvalid !== 1'b1 && n < 20);
    vec_cnt++;
    if (n != 2 || Bvalid !== 1'b1)
      begin err_cnt++; $display("FAIL wr_latency: got %0d cycles Bvalid=%b, want 2 cycles", n, Bvalid); end
    for (int i = 0; i < b_hold; i++) begin
      vec_cnt++;
      if (Bvalid !== 1'b1 || AWready !== 1'b0 || Wready !== 1'b0)
        begin err_cnt++; $display("FAIL b_hold: Bvalid=%b AWready=%b Wready=%b, want 1/0/0", Bvalid, AWready, Wready); end
      @(negedge clk);
    end
    Bready = 1;
    @(posedge clk);
    @(negedge clk);
    Bready = 0;
    vec_cnt++;
    if (Bvalid !== 1'b0 || AWready !== 1'b1 || Wready !== 1'b1)
      begin err_cnt++; $display("FAIL b_release: Bvalid=%b AWready=%b Wready=%b, want 0/1/1", Bvalid, AWready, Wready); end
  endtask

  task automatic read_txn(input logic [31:0] addr, input int r_hold);
    logic [31:0] exp_v, first_v;
    int n;
    exp_q.push_back((addr[31:12] == 20'h0) ? model[addr[11:2]] : 32'h0);
    @(negedge clk);
    ARvalid = 1; ARdata = addr; ARprot = 3'd5;
    vec_cnt++;
    if (ARready !== 1'b1)
      begin err_cnt++; $display("FAIL ar_ready: got %b want 1", ARready); end
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk); ARvalid = 0; n++;
    end while (Rvalid !== 1'b1 && n < 20);
    vec_cnt++;
    if (n != 2 || Rvalid !== 1'b1)
      begin err_cnt++; $display("FAIL rd_latency: got %0d cycles Rvalid=%b, want 2 cycles", n, Rvalid); end
    first_v = Rdata;
    for (int i = 0; i < r_hold; i++) begin
      @(negedge clk);
      vec_cnt++;
      if (Rvalid !== 1'b1 || ARready !== 1'b0 || Rdata !== first_v)
        begin err_cnt++; $display("FAIL r_hold: Rvalid=%b ARready=%b Rdata=%h, want 1/0/%h", Rvalid, ARready, Rdata, first_v); end
    end
    exp_v = exp_q.pop_front();
    vec_cnt++;
    if (Rdata !== exp_v)
      begin err_cnt++; $display("FAIL rdata @%h: got %h want %h", addr, Rdata, exp_v); end
    RReady = 1;
    @(posedge clk);
    @(negedge clk);
    RReady = 0;
    vec_cnt++;
    if (Rvalid !== 1'b0 || ARready !== 1'b1 || Rdata !== exp_v)
      begin err_cnt++; $display("FAIL r_release: Rvalid=%b ARready=%b Rdata=%h, want 0/1/%h", Rvalid, ARready, Rdata, exp_v); end
  endtask

  task automatic test_reset;
    rstn = 1;
    AWvalid = 0; AWdata = 0; AWprot = 0; Wvalid = 0; Wdata = 0; Wstrb = 0; Bready = 0;
    ARvalid = 0; ARdata = 0; ARprot = 0; RReady = 0;
    #1 rstn = 0;
    @(negedge clk); @(negedge clk);
    vec_cnt++;
    if ({AWready, Wready, ARready, Bvalid, Rvalid} !== 5'b0 || Rdata !== 32'h0)
      begin err_cnt++; $display("FAIL reset_outputs: rdy/vld=%b Rdata=%h, want 00000/0", {AWready, Wready, ARready, Bvalid, Rvalid}, Rdata); end
    rstn = 1;
    @(posedge clk); #1;
    vec_cnt++;
    if ({AWready, Wready, ARready, Bvalid, Rvalid} !== 5'b11100)
      begin err_cnt++; $display("FAIL post_reset_ready: got %b want 11100", {AWready, Wready, ARready, Bvalid, Rvalid}); end
  endtask

  task automatic test_basic;
    write_txn(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
    read_txn(32'h0000_0010, 0);
  endtask

  task automatic test_w_first_strobe;
    write_txn(32'h0000_0010, 32'h1122_3344, 4'b0101, 3, 0, 0);
    read_txn(32'h0000_0010, 0);
  endtask

  task automatic test_backpressure;
    write_txn(32'h0000_0040, 32'h0BAD_CAFE, 4'hF, 0, 0, 5);
    read_txn(32'h0000_0040, 5);
  endtask

  task automatic test_out_of_range;
    write_txn(32'h0000_0000, 32'hCAFE_F00D, 4'hF, 0, 0, 0);
    write_txn(32'h0000_1000, 32'h0000_0055, 4'hF, 1, 0, 0);
    read_txn(32'h0000_0000, 0);
    read_txn(32'h0000_1000, 0);
  endtask

  task automatic test_collision;
    logic [31:0] exp_v;
    write_txn(32'h0000_0020, 32'h0000_000A, 4'hF, 0, 0, 0);
    @(negedge clk);
    AWvalid = 1; AWdata = 32'h20; Wvalid = 1; Wdata = 32'h0000_000B; Wstrb = 4'hF;
    ARvalid = 1; ARdata = 32'h20;
    exp_q.push_back(model[8]);
    model_write(32'h20, 32'h0000_000B, 4'hF);
    @(posedge clk);
    @(negedge clk);
    AWvalid = 0; Wvalid = 0; ARvalid = 0;
    @(negedge clk);
    vec_cnt++;
    if (Bvalid !== 1'b1 || Rvalid !== 1'b1)
      begin err_cnt++; $display("FAIL collide_valid: Bvalid=%b Rvalid=%b, want 1/1", Bvalid, Rvalid); end
    exp_v = exp_q.pop_front();
    vec_cnt++;
    if (Rdata !== exp_v)
      begin err_cnt++; $display("FAIL collide_rdata: got %h want %h", Rdata, exp_v); end
    Bready = 1; RReady = 1;
    @(posedge clk);
    @(negedge clk);
    Bready = 0; RReady = 0;
    read_txn(32'h0000_0020, 0);
  endtask

  task automatic test_reset_abort;
    write_txn(32'h0000_0030, 32'h1234_5678, 4'hF, 0, 0, 0);
    read_txn(32'h0000_0030, 0);
    @(negedge clk);
    AWvalid = 1; AWdata = 32'h30;
    @(posedge clk);
    @(negedge clk);
    AWvalid = 0; Wvalid = 1; Wdata = 32'hFFFF_FFFF; Wstrb = 4'hF;
    rstn = 0;
    #1;
    vec_cnt++;
    if ({AWready, Wready, ARready, Bvalid, Rvalid} !== 5'b0 || Rdata !== 32'h0)
      begin err_cnt++; $display("FAIL abort_reset_outputs: rdy/vld=%b Rdata=%h, want 00000/0", {AWready, Wready, ARready, Bvalid, Rvalid}, Rdata); end
    @(negedge clk);
    Wvalid = 0;
    rstn = 1;
    @(posedge clk); #1;
    vec_cnt++;
    if ({AWready, Wready, ARready} !== 3'b111)
      begin err_cnt++; $display("FAIL abort_ready: got %b want 111", {AWready, Wready, ARready}); end
    write_txn(32'h0000_0034, 32'h0000_0009, 4'hF, 2, 0, 0);
    read_txn(32'h0000_0030, 0);
    read_txn(32'h0000_0034, 0);
  endtask

  task automatic test_back_to_back;
    logic [9:0]  idx;
    logic [31:0] addr;
    for (int k = 0; k < 8; k++) begin
      idx  = 10'($urandom_range(64, 1023));
      addr = {20'h0, idx, 2'($urandom_range(0, 3))};
      write_txn(addr, $urandom, 4'hF, 0, 0, 0);
      write_txn(addr, $urandom, 4'($urandom_range(1, 15)), $urandom_range(0, 2), $urandom_range(0, 2), 0);
      read_txn({20'h0, idx, 2'b00}, $urandom_range(0, 1));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_w_first_strobe();
    test_backpressure();
    test_out_of_range();
    test_collision();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
